// File: rtl/register_bank_param_if.sv
// Decode/write-back side signal bundle for register_bank_param.
// The master drives addresses and write-back; the slave (the bank) returns read data, hazards and debug views.
interface register_bank_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] i_AddrReg1;
  logic [ADDR_W-1:0] i_AddrReg2;
  logic [ADDR_W-1:0] i_AddrRegDest;
  logic              i_WriteBack;
  logic [DATA_W-1:0] i_WriteData;
  logic [DATA_W-1:0] o_Data1;
  logic [DATA_W-1:0] o_Data2;
  logic              o_Hazard1;
  logic              o_Hazard2;
  logic [DATA_W-1:0] o_RegShowing1;
  logic [DATA_W-1:0] o_RegShowing2;

  modport master (
    output i_AddrReg1, i_AddrReg2, i_AddrRegDest, i_WriteBack, i_WriteData,
    input  o_Data1, o_Data2, o_Hazard1, o_Hazard2, o_RegShowing1, o_RegShowing2
  );

  modport slave (
    input  i_AddrReg1, i_AddrReg2, i_AddrRegDest, i_WriteBack, i_WriteData,
    output o_Data1, o_Data2, o_Hazard1, o_Hazard2, o_RegShowing1, o_RegShowing2
  );
endinterface

// File: rtl/register_bank_param.sv
// Register file: 2 registered read ports (1-cycle), write-back commits WB_DELAY edges after issue; no backpressure.
// Defining REGBANK_BYPASS_EN forwards committing data onto same-edge reads and drops the last stage from hazards.
module register_bank_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int WB_DELAY = 1,
  parameter int ZERO_R0  = 0
) (
  input logic i_CLK,
  input logic i_RST_N,
  register_bank_param_if.slave bus
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int PD    = (WB_DELAY > 0) ? WB_DELAY : 1;
`ifdef REGBANK_BYPASS_EN
  localparam int HZ_N  = (WB_DELAY > 0) ? WB_DELAY - 1 : 0;
`else
  localparam int HZ_N  = WB_DELAY;
`endif

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              pend_v_q [PD];
  logic [ADDR_W-1:0] pend_a_q [PD];
  logic [DATA_W-1:0] data1_q, data2_q;
  logic [DATA_W-1:0] data1_d, data2_d;
  logic [DATA_W-1:0] show1, show2;
  logic              haz1, haz2;
  logic              commit_v;
  logic [ADDR_W-1:0] commit_a;

  // With no delay stages the issue itself is the commit.
  always_comb begin
    if (WB_DELAY == 0) begin
      commit_v = bus.i_WriteBack;
      commit_a = bus.i_AddrRegDest;
    end else begin
      commit_v = pend_v_q[PD-1];
      commit_a = pend_a_q[PD-1];
    end
    if (ZERO_R0 != 0 && commit_a == '0) commit_v = 1'b0;
  end

  always_comb begin
    show1 = regs_q[bus.i_AddrReg1];
    show2 = regs_q[bus.i_AddrReg2];
    if (ZERO_R0 != 0 && bus.i_AddrReg1 == '0) show1 = '0;
    if (ZERO_R0 != 0 && bus.i_AddrReg2 == '0) show2 = '0;
  end

  always_comb begin
    data1_d = show1;
    data2_d = show2;
`ifdef REGBANK_BYPASS_EN
    if (commit_v && commit_a == bus.i_AddrReg1) data1_d = bus.i_WriteData;
    if (commit_v && commit_a == bus.i_AddrReg2) data2_d = bus.i_WriteData;
`endif
  end

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = 0; k < PD; k++) begin
      if (k < HZ_N) begin
        if (pend_v_q[k] && pend_a_q[k] == bus.i_AddrReg1) haz1 = 1'b1;
        if (pend_v_q[k] && pend_a_q[k] == bus.i_AddrReg2) haz2 = 1'b1;
      end
    end
    if (ZERO_R0 != 0 && bus.i_AddrReg1 == '0) haz1 = 1'b0;
    if (ZERO_R0 != 0 && bus.i_AddrReg2 == '0) haz2 = 1'b0;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      for (int k = 0; k < PD; k++) begin
        pend_v_q[k] <= 1'b0;
        pend_a_q[k] <= '0;
      end
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      pend_v_q[0] <= bus.i_WriteBack;
      pend_a_q[0] <= bus.i_AddrRegDest;
      for (int k = 1; k < PD; k++) begin
        pend_v_q[k] <= pend_v_q[k-1];
        pend_a_q[k] <= pend_a_q[k-1];
      end
      if (commit_v) regs_q[commit_a] <= bus.i_WriteData;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  assign bus.o_Data1       = data1_q;
  assign bus.o_Data2       = data2_q;
  assign bus.o_Hazard1     = haz1;
  assign bus.o_Hazard2     = haz2;
  assign bus.o_RegShowing1 = show1;
  assign bus.o_RegShowing2 = show2;

endmodule

// File: tb/tb_register_bank_param.sv
// Two banks (WB_DELAY=1 plain, WB_DELAY=3 with ZERO_R0) share one stimulus stream and are
// scored against an issue-history model of the register file.
module tb_register_bank_param;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [7:0] d1, d2, s1, s2;
    logic       h1, h2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_bank_param_if #(.DATA_W(8), .ADDR_W(3)) ifa ();
  register_bank_param_if #(.DATA_W(8), .ADDR_W(3)) ifb ();

  register_bank_param #(.DATA_W(8), .ADDR_W(3), .WB_DELAY(1), .ZERO_R0(0)) dut_a (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(ifa)
  );
  register_bank_param #(.DATA_W(8), .ADDR_W(3), .WB_DELAY(3), .ZERO_R0(1)) dut_b (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(ifb)
  );

  int dly [2] = '{1, 3};
  int zr  [2] = '{0, 1};
  logic [7:0] mem [2][8];
  bit         hist_wb   [0:4095];
  logic [2:0] hist_dest [0:4095];
  int n = 0;
  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input int i, input logic [2:0] a);
    if (zr[i] != 0 && a == 3'd0) return 8'h00;
    return mem[i][a];
  endfunction

  // A write issued at edge e is uncommitted after edge n while e + delay > n.
  function automatic logic haz(input int i, input logic [2:0] a);
    int lo;
    if (zr[i] != 0 && a == 3'd0) return 1'b0;
    lo = n - dly[i] + 1 + (BYP ? 1 : 0);
    if (lo < 1) lo = 1;
    for (int e = lo; e <= n; e++)
      if (hist_wb[e] && hist_dest[e] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 8; r++) mem[i][r] = 8'h00;
    for (int e = 0; e <= n; e++) hist_wb[e] = 1'b0;
  endtask

  task automatic drive(input logic [2:0] a1, input logic [2:0] a2, input logic wb,
                       input logic [2:0] dst, input logic [7:0] wd);
    exp_t x;
    int e;
    bit cv;
    logic [2:0] ca;
    @(negedge clk);
    ifa.i_AddrReg1 = a1;  ifb.i_AddrReg1 = a1;
    ifa.i_AddrReg2 = a2;  ifb.i_AddrReg2 = a2;
    ifa.i_WriteBack = wb; ifb.i_WriteBack = wb;
    ifa.i_AddrRegDest = dst; ifb.i_AddrRegDest = dst;
    ifa.i_WriteData = wd; ifb.i_WriteData = wd;
    n++;
    hist_wb[n] = wb;
    hist_dest[n] = dst;
    for (int i = 0; i < 2; i++) begin
      cv = 1'b0;
      ca = 3'd0;
      e = n - dly[i];
      if (e >= 1 && hist_wb[e]) begin
        cv = 1'b1;
        ca = hist_dest[e];
      end
      if (zr[i] != 0 && ca == 3'd0) cv = 1'b0;
      x.d1 = rd(i, a1);
      x.d2 = rd(i, a2);
      if (BYP && cv && ca == a1) x.d1 = wd;
      if (BYP && cv && ca == a2) x.d2 = wd;
      if (cv) mem[i][ca] = wd;
      x.s1 = rd(i, a1);
      x.s2 = rd(i, a2);
      x.h1 = haz(i, a1);
      x.h2 = haz(i, a2);
      if (i == 0) qa.push_back(x);
      else qb.push_back(x);
    end
  endtask

  task automatic rnd_cycle();
    drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
  endtask

  task automatic cmp_rec(input string tag, input exp_t x,
                         input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] s1, input logic [7:0] s2,
                         input logic h1, input logic h2);
    chk({tag, " o_Data1"}, int'(d1), int'(x.d1));
    chk({tag, " o_Data2"}, int'(d2), int'(x.d2));
    chk({tag, " o_RegShowing1"}, int'(s1), int'(x.s1));
    chk({tag, " o_RegShowing2"}, int'(s2), int'(x.s2));
    chk({tag, " o_Hazard1"}, int'(h1), int'(x.h1));
    chk({tag, " o_Hazard2"}, int'(h2), int'(x.h2));
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        x = qa.pop_front();
        cmp_rec("A", x, ifa.o_Data1, ifa.o_Data2, ifa.o_RegShowing1, ifa.o_RegShowing2,
                ifa.o_Hazard1, ifa.o_Hazard2);
      end
      if (qb.size() > 0) begin
        x = qb.pop_front();
        cmp_rec("B", x, ifb.o_Data1, ifb.o_Data2, ifb.o_RegShowing1, ifb.o_RegShowing2,
                ifb.o_Hazard1, ifb.o_Hazard2);
      end
    end
  end

  // Mid-cycle reset pulse: outputs must clear at once, and pending writes are forgotten.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst A o_Data1", int'(ifa.o_Data1), 0);
    chk("rst A o_Data2", int'(ifa.o_Data2), 0);
    chk("rst B o_Data1", int'(ifb.o_Data1), 0);
    chk("rst B o_Data2", int'(ifb.o_Data2), 0);
    chk("rst B o_Hazard1", int'(ifb.o_Hazard1), 0);
    chk("rst A o_RegShowing1", int'(ifa.o_RegShowing1), 0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : stim
    ifa.i_AddrReg1 = 3'd0; ifa.i_AddrReg2 = 3'd0; ifa.i_AddrRegDest = 3'd0;
    ifa.i_WriteBack = 1'b0; ifa.i_WriteData = 8'h00;
    ifb.i_AddrReg1 = 3'd0; ifb.i_AddrReg2 = 3'd0; ifb.i_AddrRegDest = 3'd0;
    ifb.i_WriteBack = 1'b0; ifb.i_WriteData = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset A o_Data1", int'(ifa.o_Data1), 0);
    chk("reset B o_Data2", int'(ifb.o_Data2), 0);
    chk("reset A o_Hazard1", int'(ifa.o_Hazard1), 0);
    rst_n = 1'b1;

    // R3 <- A5 (data presented on the commit edge), then read back.
    drive(3'd3, 3'd3, 1'b1, 3'd3, 8'h11);
    drive(3'd3, 3'd5, 1'b0, 3'd0, 8'hA5);
    drive(3'd3, 3'd3, 1'b0, 3'd0, 8'h00);
    drive(3'd3, 3'd3, 1'b0, 3'd0, 8'h00);
    // Back-to-back writes to R2, later data wins.
    drive(3'd2, 3'd2, 1'b1, 3'd2, 8'h00);
    drive(3'd2, 3'd2, 1'b1, 3'd2, 8'h11);
    drive(3'd2, 3'd2, 1'b0, 3'd0, 8'h22);
    for (int i = 0; i < 4; i++) drive(3'd2, 3'd4, 1'b0, 3'd0, 8'h33);
    // Long-delay hazard window on R5 while R4 stays clean.
    drive(3'd4, 3'd5, 1'b1, 3'd5, 8'h00);
    for (int i = 0; i < 5; i++) drive(3'd4, 3'd5, 1'b0, 3'd0, 8'h5C);
    // Writes to R0 on the ZERO_R0 bank never show.
    drive(3'd0, 3'd0, 1'b1, 3'd0, 8'hFF);
    for (int i = 0; i < 5; i++) drive(3'd0, 3'd0, 1'b0, 3'd0, 8'hFF);

    // Preload, leave writes in flight, then reset.
    for (int i = 0; i < 8; i++) drive(3'(i), 3'(7 - i), 1'b1, 3'(i), 8'(8'h40 + i));
    drive(3'd1, 3'd6, 1'b1, 3'd6, 8'hEE);
    do_reset();

    // Same-edge commit and read of R6 from a known 00.
    drive(3'd6, 3'd6, 1'b1, 3'd6, 8'h00);
    drive(3'd6, 3'd6, 1'b0, 3'd0, 8'h7F);
    for (int i = 0; i < 4; i++) drive(3'd6, 3'd6, 1'b0, 3'd0, 8'h7F);

    for (int c = 0; c < 600; c++) rnd_cycle();
    do_reset();
    for (int c = 0; c < 600; c++) rnd_cycle();

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", qa.size() + qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
